bus_arbiter: RTL and testbench

Parametrised successor to the fixed-priority combinational bus mux in the 8-bit CPU top level. Arbitrates NSRC sources onto one shared WIDTH-bit bus using registered one-hot grants. Supports fixed-priority or round-robin mode, multi-cycle bus locking, an optional bus keeper, and a saturating contention counter. Sits between the datapath modules (pc, memory, registers, adder, ir) and their shared bus; the controller's enable lines become req inputs.

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU datapath bus: default width, source ordering
// and small index helpers used by the bus arbiter.
package cpu_bus_pkg;

    localparam int CPU_BUS_W = 8;
    localparam int CPU_NSRC  = 5;

    // Source ordering on the shared bus; index 0 has the highest fixed priority.
    localparam int SRC_IR    = 0;
    localparam int SRC_ADDER = 1;
    localparam int SRC_A     = 2;
    localparam int SRC_MEM   = 3;
    localparam int SRC_PC    = 4;

    function automatic int next_idx(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational priority picker: first asserted request at or after 'start',
// wrapping to index 0. A start of 0 gives plain lowest-index-wins priority.
module rr_pick #(
    parameter int NSRC  = 5,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NSRC-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Upper segment [start, NSRC-1] first, then the wrapped segment [0, start-1].
        for (int i = 0; i < NSRC; i++) begin
            if (!any && req[i] && (i >= int'(start))) begin
                any       = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (!any && req[i]) begin
                any       = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: registered one-hot grants with fixed-priority or round-robin
// selection, per-source bus locking, optional bus keeper and a saturating conflict counter.
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH   = CPU_BUS_W,
    parameter int NSRC    = CPU_NSRC,
    parameter int RR_MODE = 0,
    parameter int HOLD    = 1,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         req,
    input  logic [NSRC*WIDTH-1:0]   data_in,
    input  logic [NSRC-1:0]         lock,
    output logic [NSRC-1:0]         grant,
    output logic [$clog2(NSRC)-1:0] grant_idx,
    output logic                    bus_valid,
    output logic [WIDTH-1:0]        bus,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int IDX_W = $clog2(NSRC);

    logic [NSRC-1:0]  r_grant;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IDX_W-1:0] r_ptr;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_keep;

    logic [IDX_W-1:0] w_start;
    logic [NSRC-1:0]  w_pick;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_locked;
    logic             w_conflict;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_bus;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_start    = (RR_MODE != 0) ? r_ptr : '0;
    assign w_locked   = r_valid && (|(r_grant & req & lock));
    assign w_conflict = ($countones(req) > 1);

    rr_pick #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (w_start),
        .onehot (w_pick),
        .idx    (w_pick_idx),
        .any    (w_any)
    );

    // Grant is one-hot, so OR-ing the masked slices selects the owner's data.
    always_comb begin
        w_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_grant[i]) begin
                w_src = w_src | data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_bus = r_valid ? w_src : ((HOLD != 0) ? r_keep : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant    <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_ptr      <= '0;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
            r_keep     <= '0;
        end else begin
            r_conflict <= w_conflict;
            if (w_conflict) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (r_valid) begin
                r_keep <= w_bus;
            end
            // A locked owner keeps the bus and freezes the round-robin pointer.
            if (!w_locked) begin
                if (w_any) begin
                    r_grant <= w_pick;
                    r_idx   <= w_pick_idx;
                    r_valid <= 1'b1;
                    if (RR_MODE != 0) begin
                        r_ptr <= IDX_W'(next_idx(int'(w_pick_idx), NSRC));
                    end
                end else begin
                    r_grant <= '0;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign grant        = r_grant;
    assign grant_idx    = r_idx;
    assign bus_valid    = r_valid;
    assign bus          = w_bus;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

    a_grant_onehot0 : assert property (@(posedge clk) $onehot0(r_grant));
    a_idx_matches   : assert property (@(posedge clk)
        (r_grant == '0) ? (r_idx == '0) : (r_grant == (NSRC'(1) << r_idx)));
    a_valid_matches : assert property (@(posedge clk) r_valid == (r_grant != '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a fixed-priority/keeper instance and a
// round-robin/no-keeper/2-bit-counter instance share one stimulus stream.
module tb_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int W = 8;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N*W-1:0] data_in;

    logic [N-1:0] grant_f, grant_r;
    logic [2:0]   idx_f, idx_r;
    logic         vld_f, vld_r;
    logic [W-1:0] bus_f, bus_r;
    logic         conf_f, conf_r;
    logic [7:0]   cnt_f;
    logic [1:0]   cnt_r;

    typedef struct packed {
        logic [4:0] grant;
        logic [2:0] idx;
        logic       vld;
        logic [7:0] bus;
        logic       conf;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_f[$];
    exp_t q_r[$];

    int total = 0;
    int bad   = 0;

    int         m_owner[2];
    int         m_ptr[2];
    int         m_cnt[2];
    logic [7:0] m_keep[2];

    always #5 clk = ~clk;

    bus_arbiter #(.WIDTH(W), .NSRC(N), .RR_MODE(0), .HOLD(1), .CNT_W(8)) u_fix (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .lock(lock),
        .grant(grant_f), .grant_idx(idx_f), .bus_valid(vld_f), .bus(bus_f),
        .conflict(conf_f), .conflict_cnt(cnt_f)
    );

    bus_arbiter #(.WIDTH(W), .NSRC(N), .RR_MODE(1), .HOLD(0), .CNT_W(2)) u_rr (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .lock(lock),
        .grant(grant_r), .grant_idx(idx_r), .bus_valid(vld_r), .bus(bus_r),
        .conflict(conf_r), .conflict_cnt(cnt_r)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] slice_of(input logic [39:0] d, input int i);
        logic [39:0] t;
        t = d >> (i * 8);
        return t[7:0];
    endfunction

    function automatic bit has(input logic [4:0] v, input int i);
        return ((v >> i) & 5'd1) != 5'd0;
    endfunction

    function automatic logic [39:0] mk(input logic [7:0] d4, input logic [7:0] d3,
                                       input logic [7:0] d2, input logic [7:0] d1,
                                       input logic [7:0] d0);
        return {d4, d3, d2, d1, d0};
    endfunction

    // Reference: owner as an integer (-1 idle), arbitration by modular search.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            int   start;
            int   win;
            int   cmax;
            e    = '0;
            cmax = (m == 0) ? 255 : 3;
            if (!rst) begin
                m_owner[m] = -1;
                m_ptr[m]   = 0;
                m_cnt[m]   = 0;
                m_keep[m]  = 8'h00;
            end else begin
                if (m_owner[m] >= 0) m_keep[m] = slice_of(data_in, m_owner[m]);
                e.conf = ($countones(req) > 1);
                if (e.conf && m_cnt[m] < cmax) m_cnt[m]++;
                if (!(m_owner[m] >= 0 && has(req, m_owner[m]) && has(lock, m_owner[m]))) begin
                    if (req == '0) begin
                        m_owner[m] = -1;
                    end else begin
                        start = (m == 1) ? m_ptr[m] : 0;
                        win   = -1;
                        for (int k = 0; k < N; k++) begin
                            if (win < 0 && has(req, (start + k) % N)) win = (start + k) % N;
                        end
                        m_owner[m] = win;
                        if (m == 1) m_ptr[m] = (win + 1) % N;
                    end
                end
            end
            e.vld   = (m_owner[m] >= 0);
            e.grant = e.vld ? 5'(1 << m_owner[m]) : 5'd0;
            e.idx   = e.vld ? 3'(m_owner[m]) : 3'd0;
            e.bus   = e.vld ? slice_of(data_in, m_owner[m]) : ((m == 0) ? m_keep[m] : 8'h00);
            e.cnt   = 8'(m_cnt[m]);
            if (m == 0) q_f.push_back(e);
            else        q_r.push_back(e);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] lk,
                         input logic [39:0] d);
        @(negedge clk);
        rst     = r;
        req     = rq;
        lock    = lk;
        data_in = d;
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic [4:0] g,
                           input logic [2:0] ix, input logic v, input logic [7:0] b,
                           input logic c, input logic [7:0] n);
        check({tag, "_grant"}, 32'(g), 32'(e.grant));
        check({tag, "_idx"},   32'(ix), 32'(e.idx));
        check({tag, "_valid"}, 32'(v), 32'(e.vld));
        check({tag, "_bus"},   32'(b), 32'(e.bus));
        check({tag, "_conf"},  32'(c), 32'(e.conf));
        check({tag, "_cnt"},   32'(n), 32'(e.cnt));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_f.size() > 0) cmp_out("fix", q_f.pop_front(), grant_f, idx_f, vld_f, bus_f, conf_f, cnt_f);
            if (q_r.size() > 0) cmp_out("rr", q_r.pop_front(), grant_r, idx_r, vld_r, bus_r, conf_r, 8'(cnt_r));
        end
    end

    initial begin
        logic [39:0] d;
        logic [4:0]  rq;
        logic [4:0]  lk;
        logic        r;
        rst = 1'b0; req = '0; lock = '0; data_in = '0;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_ptr[m] = 0; m_cnt[m] = 0; m_keep[m] = 8'h00;
        end

        // Reset held with every source requesting.
        d = mk(8'h44, 8'h33, 8'h22, 8'h11, 8'h99);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 5'b11111, 5'b00000, d);
            settle();
            check("rst_grant", 32'(grant_f), 32'd0);
            check("rst_bus", 32'(bus_f), 32'd0);
            check("rst_cnt", 32'(cnt_f), 32'd0);
        end
        drive(1'b1, 5'b11111, 5'b00000, d);
        settle();
        check("rel_grant", 32'(grant_f), 32'b00001);
        check("rel_conf", 32'(conf_f), 32'd1);
        check("rel_cnt", 32'(cnt_f), 32'd1);

        // Fixed priority between sources 2 and 4.
        d = mk(8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00);
        drive(1'b1, 5'b10100, 5'b00000, d);
        settle();
        check("fp_grant", 32'(grant_f), 32'b00100);
        check("fp_bus", 32'(bus_f), 32'hA5);
        drive(1'b1, 5'b10000, 5'b00000, d);
        settle();
        check("fp_grant2", 32'(grant_f), 32'b10000);
        check("fp_bus2", 32'(bus_f), 32'h3C);

        // Round-robin rotation and pointer wrap.
        drive(1'b1, 5'b00000, 5'b00000, d);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'b11111, 5'b00000, d);
            settle();
            check($sformatf("rr_seq%0d", i), 32'(idx_r), 32'(i % N));
        end

        // Lock held by SRC_MEM against competing requests.
        drive(1'b1, 5'b01000, 5'b01000, d);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'b01011, 5'b01000, d);
            settle();
            check($sformatf("lock_f%0d", i), 32'(grant_f), 32'(1 << SRC_MEM));
            check($sformatf("lock_r%0d", i), 32'(grant_r), 32'(1 << SRC_MEM));
        end
        drive(1'b1, 5'b01011, 5'b00000, d);
        settle();
        check("unlock_f", 32'(grant_f), 32'b00001);

        // Keeper: value held on the fixed instance, zero on the HOLD=0 instance.
        d = mk(8'h00, 8'h00, 8'h00, 8'h7E, 8'h00);
        drive(1'b1, 5'b00010, 5'b00000, d);
        drive(1'b1, 5'b00000, 5'b00000, d);
        settle();
        check("keep_valid", 32'(vld_f), 32'd0);
        check("keep_bus_f", 32'(bus_f), 32'h7E);
        check("keep_bus_r", 32'(bus_r), 32'h00);

        // Counter saturation on the 2-bit instance, then reset during a lock.
        drive(1'b0, 5'b00000, 5'b00000, d);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'b00011, 5'b00001, d);
            settle();
            check($sformatf("sat%0d", i), 32'(cnt_r), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        drive(1'b0, 5'b00011, 5'b00001, d);
        settle();
        check("rstlock_grant", 32'(grant_r), 32'd0);
        check("rstlock_valid", 32'(vld_f), 32'd0);
        check("rstlock_cnt", 32'(cnt_f), 32'd0);
        check("rstlock_conf", 32'(conf_r), 32'd0);

        // Randomized traffic with occasional resets and idle cycles.
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 39) != 0);
            rq = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            lk = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            d  = {8'($urandom), 32'($urandom)};
            drive(r, rq, lk, d);
        end

        drive(1'b1, 5'b00000, 5'b00000, d);
        settle();
        @(posedge clk);
        #3;
        check("drain_f", 32'(q_f.size()), 32'd0);
        check("drain_r", 32'(q_r.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
